// File: rtl/scoreboard_hazard_unit.sv
// ---------------------------------------------------------------------------
// scoreboard_hazard_unit
//
// In-order issue scoreboard for a single ID stage. One countdown per
// architectural register records how many cycles remain until that
// register's pending result is available. An incoming instruction is held
// (op_stall) on a read-after-write hazard on either source, or on a
// write-after-write hazard that would let a shorter-latency write complete
// before an older, longer one. Otherwise it is accepted (op_issue) and its
// destination countdown is loaded. Register 0 is never tracked.
//
// Parameters
//   REG_ADDR_W : register-address width (2**REG_ADDR_W registers)
//   MAX_LAT    : largest result latency that can be tracked
//   FWD_EN     : 1 = a result can be consumed in its final cycle
//
// Ports
//   ip_clk          : clock
//   ip_rst          : synchronous active-high reset
//   ip_issue_valid  : ID-stage instruction requests issue
//   ip_rs / ip_rt   : source registers A / B
//   ip_use_rs/_rt   : instruction reads rs / rt
//   ip_wr_en        : instruction writes ip_dest
//   ip_dest         : destination register
//   ip_lat          : cycles until the result is available
//   ip_flush        : squash all in-flight writes
//   op_stall        : hold the ID stage this cycle
//   op_issue        : instruction accepted this cycle
//   op_pending_cnt  : number of registers with a pending write
//   op_stall_cycles : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module scoreboard_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 8,
  parameter int FWD_EN     = 1,
  localparam int CW        = $clog2(MAX_LAT + 1)
) (
  input  logic                  ip_clk,
  input  logic                  ip_rst,
  input  logic                  ip_issue_valid,
  input  logic [REG_ADDR_W-1:0] ip_rs,
  input  logic [REG_ADDR_W-1:0] ip_rt,
  input  logic                  ip_use_rs,
  input  logic                  ip_use_rt,
  input  logic                  ip_wr_en,
  input  logic [REG_ADDR_W-1:0] ip_dest,
  input  logic [CW-1:0]         ip_lat,
  input  logic                  ip_flush,
  output logic                  op_stall,
  output logic                  op_issue,
  output logic [REG_ADDR_W:0]   op_pending_cnt,
  output logic [15:0]           op_stall_cycles
);

  localparam int            NREG      = 1 << REG_ADDR_W;
  localparam int            PW        = REG_ADDR_W + 1;
  localparam logic [CW-1:0] LAT_MAX_C = CW'(MAX_LAT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic [15:0]   stall_cyc_q;
  logic [15:0]   stall_cyc_d;

  logic [CW-1:0] eff_lat;
  logic [CW-1:0] cnt_rs;
  logic [CW-1:0] cnt_rt;
  logic [CW-1:0] cnt_dest;
  logic          raw_rs;
  logic          raw_rt;
  logic          waw;
  logic          load_en;
  logic [PW-1:0] pending;

  // Latency 0 is treated as a single-cycle result; anything beyond the
  // tracking range is clamped to the longest trackable latency.
  always_comb begin
    if (ip_lat == '0) begin
      eff_lat = ONE_C;
    end else if (ip_lat > LAT_MAX_C) begin
      eff_lat = LAT_MAX_C;
    end else begin
      eff_lat = ip_lat;
    end
  end

  // All hazard checks look at the current (pre-update) countdowns, so a
  // register named as rs, rt and dest at once is judged independently.
  assign cnt_rs   = cnt_q[ip_rs];
  assign cnt_rt   = cnt_q[ip_rt];
  assign cnt_dest = cnt_q[ip_dest];

  function automatic logic raw_hazard(input logic                  used,
                                      input logic [REG_ADDR_W-1:0] src,
                                      input logic [CW-1:0]         cnt);
    logic busy;
    // With forwarding, a result in its last cycle (count 1) is consumable.
    busy = (FWD_EN != 0) ? (cnt > ONE_C) : (cnt != '0);
    return used && (src != '0) && busy;
  endfunction

  always_comb begin
    raw_rs = raw_hazard(ip_use_rs, ip_rs, cnt_rs);
    raw_rt = raw_hazard(ip_use_rt, ip_rt, cnt_rt);
    // A new write must not finish ahead of an older write to the same reg.
    waw    = ip_wr_en && (ip_dest != '0) && (cnt_dest > eff_lat);
  end

  assign op_stall = ip_issue_valid && !ip_flush && (raw_rs || raw_rt || waw);
  assign op_issue = ip_issue_valid && !ip_flush && !op_stall;
  assign load_en  = op_issue && ip_wr_en && (ip_dest != '0);

  // Countdown update: flush clears everything, an accepted write reloads its
  // destination, all other live entries count down towards zero.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (ip_flush) begin
        cnt_d[r] = '0;
      end else if (load_en && (ip_dest == REG_ADDR_W'(r))) begin
        cnt_d[r] = eff_lat;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - ONE_C;
      end
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    pending = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (cnt_q[r] != '0) begin
        pending = pending + PW'(1);
      end
    end
  end

  assign op_pending_cnt = pending;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    if (op_stall && (stall_cyc_q != '1)) begin
      stall_cyc_d = stall_cyc_q + 16'd1;
    end
  end

  assign op_stall_cycles = stall_cyc_q;

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cyc_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cyc_q <= stall_cyc_d;
    end
  end

endmodule
